// File: rtl/rom_raster_scan_ctrl_pkg.sv
// Shared types and default geometry for the pattern-ROM raster scan controller.
package rom_scan_pkg;

  localparam int ROWS   = 48;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = 6;
  localparam int COL_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/rom_raster_scan_ctrl.sv
// Walks the pattern ROM row by row and serialises each word MSB-first onto a
// valid/ready pixel stream with line/frame markers.
module rom_raster_scan_ctrl #(
  parameter int ROWS   = rom_scan_pkg::ROWS,
  parameter int WIDTH  = rom_scan_pkg::WIDTH,
  parameter int ADDR_W = rom_scan_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
);
  import rom_scan_pkg::*;

  localparam int COL_LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COL_LW-1:0] COL_LAST = COL_LW'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COL_LW-1:0]   col_q, col_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic                done_q, done_d;
  logic                in_shift;
  logic                beat;

  assign in_shift = (state_q == SHIFT);
  assign beat     = in_shift && pix_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      addr_q  <= '0;
      col_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    addr_d  = addr_q;
    col_d   = col_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    // abort wins over start and over a beat landing in the same cycle
    if (abort) begin
      state_d = IDLE;
      row_d   = '0;
      addr_d  = '0;
      col_d   = '0;
      shreg_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
            row_d   = '0;
            addr_d  = '0;
          end
        end
        FETCH: begin
          shreg_d = rom_data;
          col_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (beat) begin
            shreg_d = shreg_q << 1;
            col_d   = col_q + 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                state_d = IDLE;
                row_d   = '0;
                addr_d  = '0;
                done_d  = 1'b1;
              end else begin
                state_d = FETCH;
                row_d   = row_q + 1'b1;
                addr_d  = row_q + 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rom_addr  = addr_q;
  assign pix_valid = in_shift;
  assign pix_data  = in_shift && shreg_q[WIDTH-1];
  assign pix_sol   = in_shift && (col_q == '0);
  assign pix_eol   = in_shift && (col_q == COL_LAST);
  assign pix_sof   = pix_sol && (row_q == '0);
  assign pix_eof   = pix_eol && (row_q == ROW_LAST);
  assign busy      = (state_q == FETCH) || in_shift;
  assign done      = done_q;

endmodule

// File: tb/tb_rom_raster_scan_ctrl.sv
// Scoreboard bench for rom_raster_scan_ctrl with a behavioural pattern ROM.
module tb_rom_raster_scan_ctrl;

  localparam int ROWS   = 48;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = 6;
  localparam int FRAME_CYC = ROWS * (WIDTH + 1) + 1;

  typedef struct packed {
    logic d;
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } pix_t;

  logic              clk = 1'b0;
  logic              rst, start, abort, pix_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic              pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof;
  logic              busy, done;

  int   n_tests = 0;
  int   n_fail  = 0;
  pix_t exp_q[$];
  pix_t mon_a;

  rom_raster_scan_ctrl #(.ROWS(ROWS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_word(input logic [5:0] r);
    if (r == 6'd0) return 64'h18000F83E1F83E0F;
    return {2'b10, r, 8'hC3, 2'b01, r, 8'h5A, 32'h0F0F_0000 | {26'd0, r}};
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic push_frame();
    logic [63:0] w;
    pix_t p;
    for (int r = 0; r < ROWS; r++) begin
      w = rom_word(6'(r));
      for (int c = 0; c < WIDTH; c++) begin
        p.d   = w[WIDTH-1-c];
        p.sol = (c == 0);
        p.eol = (c == WIDTH - 1);
        p.sof = (c == 0) && (r == 0);
        p.eof = (c == WIDTH - 1) && (r == ROWS - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic run_to_done(input bit rnd, input int bound, output int cyc);
    cyc = 0;
    forever begin
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (done) break;
      if (cyc >= bound) begin
        chk("done_timeout", 64'(cyc), 64'(bound + 1));
        break;
      end
    end
    pix_ready = 1'b1;
  endtask

  // Monitor: every presented pixel is checked against the queue head; it is
  // popped only on a beat, so stalled pixels must match the same entry again.
  always @(negedge clk) begin
    if (pix_valid) begin
      mon_a = '{d: pix_data, sol: pix_sol, eol: pix_eol, sof: pix_sof, eof: pix_eof};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pixel got=%b req=none", mon_a);
      end else begin
        if (mon_a !== exp_q[0]) begin
          n_fail++;
          $display("FAIL pixel got=%b req=%b left=%0d", mon_a, exp_q[0], exp_q.size());
        end
        if (pix_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int  cyc;
    bit  seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        {55'd0, pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof, busy, done, 1'b0},
        64'd0);
    chk("reset_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Single frame with the sink always ready
    pix_ready = 1'b1;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_busy", {62'd0, busy, pix_valid}, 64'b10);
    chk("fetch_addr", 64'(rom_addr), 64'd0);
    tick();
    chk("first_pix", {59'd0, pix_valid, pix_sof, pix_sol, pix_eol, pix_data}, 64'b11100);
    repeat (3) tick();
    chk("line0_pix3", 64'(pix_data), 64'd1);
    tick();
    chk("line0_pix4", 64'(pix_data), 64'd1);
    repeat (59) tick();
    chk("line0_eol", {62'd0, pix_eol, pix_sol}, 64'b10);
    tick();
    chk("bubble", {62'd0, pix_valid, busy}, 64'b01);
    chk("bubble_addr", 64'(rom_addr), 64'd1);
    run_to_done(1'b0, 4000, cyc);
    chk("frame_cycles", 64'(66 + cyc), 64'(FRAME_CYC));
    tick();
    chk("done_pulse", {62'd0, done, busy}, 64'd0);
    chk("frame1_drained", 64'(exp_q.size()), 64'd0);

    // Random backpressure
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(1'b1, 20000, cyc);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_done", 64'(done), 64'd1);

    // Abort at row 10, column 20
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (671) tick();
    chk("abort_row", 64'(rom_addr), 64'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_idle", {62'd0, pix_valid, busy}, 64'd0);
    chk("abort_addr", 64'(rom_addr), 64'd0);
    seen = 1'b0;
    repeat (5) begin
      seen |= done;
      tick();
    end
    seen |= done;
    chk("abort_no_done", 64'(seen), 64'd0);
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_sof", {62'd0, pix_valid, pix_sof}, 64'b11);
    run_to_done(1'b0, 4000, cyc);
    chk("restart_cycles", 64'(cyc + 2), 64'(FRAME_CYC));
    chk("restart_drained", 64'(exp_q.size()), 64'd0);

    // Start pulses while busy are ignored
    push_frame();
    start = 1'b1;
    tick();
    cyc = 1;
    for (int i = 0; i < 4000; i++) begin
      start = ((i % 97) == 50);
      tick();
      cyc++;
      if (done) break;
    end
    start = 1'b0;
    chk("busy_start_cycles", 64'(cyc), 64'(FRAME_CYC));
    chk("busy_start_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back frames with start held high
    push_frame();
    push_frame();
    start = 1'b1;
    run_to_done(1'b0, 4000, cyc);
    chk("b2b_done_addr", {57'd0, rom_addr, pix_valid}, 64'd0);
    tick();
    chk("b2b_refetch", {57'd0, rom_addr, busy}, 64'd1);
    start = 1'b0;
    run_to_done(1'b0, 4000, cyc);
    chk("b2b_second_cycles", 64'(cyc + 1), 64'(FRAME_CYC));
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Reset during SHIFT on row 5
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (335) tick();
    chk("rst_row5", {57'd0, rom_addr, pix_valid}, {57'd0, 6'd5, 1'b1});
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs",
        {55'd0, pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof, busy, done, 1'b0},
        64'd0);
    chk("rst_mid_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("rst_no_done", 64'(done), 64'd0);
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_refetch", {57'd0, rom_addr, busy}, 64'd1);
    run_to_done(1'b0, 4000, cyc);
    chk("rst_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_raster_scan_ctrl.md
Name: rom_raster_scan_ctrl

Overview:
Sequences the 48x64 bitmap pattern ROM for display. It walks ROM rows 0..ROWS-1 and serialises each 64-bit word MSB-first onto a valid/ready pixel stream, with line and frame markers. It sits between the pattern ROM (combinational, 6-bit address, 64-bit data) and the downstream pixel sink or display driver.

Parameters:
ROWS, 48, number of ROM rows per frame (1..2**ADDR_W)
WIDTH, 64, bits per ROM word = pixels per line
ADDR_W, 6, ROM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  cancel the current frame; sampled in any state
rom_addr  out  ADDR_W  address to the pattern ROM; registered
rom_data  in  WIDTH  combinational ROM output for rom_addr
pix_valid  out  1  pixel available
pix_ready  in  1  sink accepts pixel
pix_data  out  1  current pixel (shift register MSB)
pix_sol  out  1  first pixel of a line (qualified by pix_valid)
pix_eol  out  1  last pixel of a line
pix_sof  out  1  first pixel of a frame
pix_eof  out  1  last pixel of a frame
busy  out  1  high in FETCH or SHIFT
done  out  1  one-cycle pulse after the eof pixel is accepted

Behaviour:
- Reset: state=IDLE; row=0, col=0, shreg=0; rom_addr=0; all outputs 0. Reset mid-frame drops the frame; no done pulse.
- FSM states: IDLE, FETCH, SHIFT. "Beat" = pix_valid && pix_ready.
- IDLE: start=1 -> FETCH with row=0, rom_addr=0. start is ignored in any other state.
- FETCH (1 cycle): rom_addr==row. At clock edge, shreg<=rom_data, col<=0, -> SHIFT.
- SHIFT: pix_valid=1, pix_data=shreg[WIDTH-1].
  - On a beat: shreg<=shreg<<1 (zero fill), col++.
  - Without a beat, hold all state. pix_data and markers stay stable while pix_valid && !pix_ready.
- Line end: beat with col==WIDTH-1.
  - If row==ROWS-1: -> IDLE, done=1 next cycle, row<=0, rom_addr<=0.
  - Else: row++, rom_addr<=row+1, -> FETCH.
- Markers (combinational from state/counters, SHIFT only):
  - sol=(col==0)
  - eol=(col==WIDTH-1)
  - sof=sol&&(row==0)
  - eof=eol&&(row==ROWS-1)
- Latency: start in cycle N -> first pix_valid in cycle N+2. There is a one-cycle pix_valid bubble (FETCH) between lines. A frame with pix_ready tied high takes ROWS*(WIDTH+1)+1 cycles from start to done.
- abort=1: -> IDLE next cycle, counters cleared, no done. abort has priority over start and over a coincident beat.
- done and start in the same cycle: done asserts in IDLE, so a start there launches a new frame immediately (back-to-back frames are legal).
- col width = clog2(WIDTH). row width = ADDR_W. Comparisons use the full width with no wrap: row never exceeds ROWS-1.

Decomposition:
- Package rom_scan_pkg: state enum (IDLE, FETCH, SHIFT), localparams ROWS, WIDTH, ADDR_W and COL_W=$clog2(WIDTH).
- No sub-module; the ROM is instantiated alongside the block, not inside it.
- One optional helper, pix_shifter (load/shift register with MSB out), if reuse is wanted elsewhere.

Test Plan:
- Reset: assert rst mid-SHIFT on row 5 -> next cycle all outputs 0, state IDLE; a following start fetches row 0 (rom_addr=0).
- Single frame, pix_ready=1, bench ROM row0=0x18000F83E1F83E0F:
  - first pix_valid at start+2, with pix_sof=pix_sol=1 and pix_data=0.
  - bits 3 and 4 of line 0 read 1.
  - pix_eol on the 64th beat, then a one-cycle bubble.
  - done exactly 48*65+1 cycles after start.
- Backpressure: pix_ready toggles randomly at 50% -> serial stream equals the ROM rows concatenated MSB-first (3072 bits), data stable during stalls, pix_eof only on bit 3071.
- Abort: abort at row 10 col 20 -> pix_valid=0 next cycle, no done; a restart begins at row 0 with pix_sof=1.
- Start while busy is ignored: start pulses during SHIFT -> no restart, row sequence 0..47 unchanged.
- Back-to-back: start held high -> a second frame begins the cycle done pulses, and rom_addr returns to 0.
